// File: rtl/ensemble_vote_combiner.sv
`default_nettype none
// ============================================================================
// Module   : ensemble_vote_combiner
// Purpose  : Aligns three per-sample classifier prediction streams (gradient
//            boost, logistic regression, MLP), forms a 2-of-3 majority vote
//            per aligned triple and emits one decision beat per triple.
//            Saturating counters track delivered decisions and ties.
// Ports    : clk, rst_n                      - clock, async active-low reset
//            s_axis_*_1 / _2 / _3            - classifier prediction slaves
//            m_axis_*                        - ensemble decision master
//            vote_count                      - decisions delivered (saturating)
//            tie_count                       - delivered ties (saturating)
// Decision : [15:0] label, [16] unanimous, [17] tie, [18] last_mismatch
// Revision : 1.0 - initial release
// ============================================================================
module ensemble_vote_combiner #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4,
    parameter int CLASS_W    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIE_SEL    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
    input  logic                  s_axis_tvalid_1,
    output logic                  s_axis_tready_1,
    input  logic                  s_axis_tlast_1,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
    input  logic                  s_axis_tvalid_2,
    output logic                  s_axis_tready_2,
    input  logic                  s_axis_tlast_2,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata_3,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_3,
    input  logic                  s_axis_tvalid_3,
    output logic                  s_axis_tready_3,
    input  logic                  s_axis_tlast_3,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,

    output logic [15:0]           vote_count,
    output logic [15:0]           tie_count
);

    localparam int          c_ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int          c_ENTRY_W = CLASS_W + 1;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Input gathering into indexable form
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_in_data [3];
    logic [2:0]            w_in_valid;
    logic [2:0]            w_in_last;
    logic [2:0]            w_ready;
    logic [2:0]            w_empty;
    logic [c_ENTRY_W-1:0]  w_head [3];
    logic                  w_pop;

    assign w_in_data[0] = s_axis_tdata_1;
    assign w_in_data[1] = s_axis_tdata_2;
    assign w_in_data[2] = s_axis_tdata_3;
    assign w_in_valid   = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1};
    assign w_in_last    = {s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1};

    assign s_axis_tready_1 = w_ready[0];
    assign s_axis_tready_2 = w_ready[1];
    assign s_axis_tready_3 = w_ready[2];

    // tkeep and the data bits above the label carry no information here.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, s_axis_tkeep_1, s_axis_tkeep_2, s_axis_tkeep_3,
                             s_axis_tdata_1[DATA_WIDTH-1:CLASS_W],
                             s_axis_tdata_2[DATA_WIDTH-1:CLASS_W],
                             s_axis_tdata_3[DATA_WIDTH-1:CLASS_W]};

    // ------------------------------------------------------------------------
    // Per-input FIFOs storing {tlast, label}
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < 3; g++) begin : g_fifo
            logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
            logic [c_ADDR_W:0]    r_wr_ptr;
            logic [c_ADDR_W:0]    r_rd_ptr;
            logic                 w_full;
            logic                 w_push;

            assign w_full = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                            (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
            assign w_empty[g] = (r_wr_ptr == r_rd_ptr);
            // Ready is gated by rst_n so it reads low throughout reset.
            assign w_ready[g] = rst_n && !w_full;
            // A full FIFO never pushes, even when it pops in the same cycle.
            assign w_push     = w_in_valid[g] && w_ready[g];
            assign w_head[g]  = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + (c_ADDR_W+1)'(1);
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + (c_ADDR_W+1)'(1);
                    end
                end
            end

            // Storage needs no reset; the pointers define validity.
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= {w_in_last[g], w_in_data[g][CLASS_W-1:0]};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Majority vote on the aligned heads
    // ------------------------------------------------------------------------
    logic [CLASS_W-1:0]    w_a;
    logic [CLASS_W-1:0]    w_b;
    logic [CLASS_W-1:0]    w_c;
    logic [CLASS_W-1:0]    w_win;
    logic                  w_tie;
    logic                  w_unan;
    logic                  w_last_any;
    logic                  w_last_mis;
    logic [DATA_WIDTH-1:0] w_dec;

    assign w_a = w_head[0][CLASS_W-1:0];
    assign w_b = w_head[1][CLASS_W-1:0];
    assign w_c = w_head[2][CLASS_W-1:0];

    assign w_unan     = (w_a == w_b) && (w_a == w_c);
    assign w_last_any = w_head[0][CLASS_W] | w_head[1][CLASS_W] | w_head[2][CLASS_W];
    assign w_last_mis = w_last_any &&
                        !(w_head[0][CLASS_W] && w_head[1][CLASS_W] && w_head[2][CLASS_W]);

    always_comb begin
        w_win = w_a;
        w_tie = 1'b0;
        if ((w_a == w_b) || (w_a == w_c)) begin
            w_win = w_a;
        end else if (w_b == w_c) begin
            w_win = w_b;
        end else begin
            w_tie = 1'b1;
            case (TIE_SEL)
                1:       w_win = w_b;
                2:       w_win = w_c;
                default: w_win = w_a;
            endcase
        end
    end

    always_comb begin
        w_dec       = '0;
        w_dec[15:0] = 16'(w_win);
        w_dec[16]   = w_unan;
        w_dec[17]   = w_tie;
        w_dec[18]   = w_last_mis;
    end

    // ------------------------------------------------------------------------
    // Single-stage output register and counters
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic [15:0]           r_vote_cnt;
    logic [15:0]           r_tie_cnt;
    logic                  w_out_free;
    logic                  w_m_hs;

    assign w_out_free = !r_m_valid || m_axis_tready;
    assign w_pop      = (w_empty == 3'b000) && w_out_free;
    assign w_m_hs     = r_m_valid && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_pop) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_dec;
            r_m_last  <= w_last_any;
        end else if (m_axis_tready) begin
            r_m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vote_cnt <= '0;
            r_tie_cnt  <= '0;
        end else if (w_m_hs) begin
            if (r_vote_cnt != c_CNT_MAX) begin
                r_vote_cnt <= r_vote_cnt + 16'd1;
            end
            if (r_m_data[17] && (r_tie_cnt != c_CNT_MAX)) begin
                r_tie_cnt <= r_tie_cnt + 16'd1;
            end
        end
    end

    assign m_axis_tdata  = r_m_data;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tkeep  = {KEEP_WIDTH{r_m_valid}};
    assign vote_count    = r_vote_cnt;
    assign tie_count     = r_tie_cnt;

endmodule
`default_nettype wire

// File: doc/ensemble_vote_combiner.md
# ensemble_vote_combiner

Downstream stage of the three-classifier ensemble (gradient boost, logistic regression, MLP). It consumes the three per-sample AXI-Stream prediction streams, buffers each independently, and aligns them sample by sample. It forms a 2-of-3 majority decision and emits one ensemble-decision beat per aligned triple on a single AXI-Stream master. It also keeps saturating decision and tie counters for host readout.

## Interface
- DATA_WIDTH, 32, stream data width on all ports
- KEEP_WIDTH, 4, tkeep width on all ports
- CLASS_W, 8, label width taken from tdata[CLASS_W-1:0]; legal 1..16
- FIFO_DEPTH, 4, per-input buffer depth; power of 2, >= 2
- TIE_SEL, 0, input index (0=stream 1, 1=stream 2, 2=stream 3) whose label wins a three-way disagreement

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_axis_tdata_k  in  DATA_WIDTH  prediction from classifier k (k = 1,2,3)
- s_axis_tkeep_k  in  KEEP_WIDTH  ignored
- s_axis_tvalid_k  in  1  beat valid
- s_axis_tready_k  out  1  buffer k not full
- s_axis_tlast_k  in  1  last sample of batch
- m_axis_tdata  out  DATA_WIDTH  decision word
- m_axis_tkeep  out  KEEP_WIDTH  all ones while valid, 0 otherwise
- m_axis_tvalid  out  1  decision valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  OR of the three tlasts of the triple
- vote_count  out  16  decisions delivered, saturating at 0xFFFF
- tie_count  out  16  delivered decisions with tie flag set, saturating

## Operation
- Per input k, a FIFO of FIFO_DEPTH entries stores {tlast, label}.
  - Push on s_axis_tvalid_k && s_axis_tready_k.
  - s_axis_tready_k = !full_k, and is forced 0 while rst_n is low.
  - When full, no push occurs even if a pop happens in the same cycle.
- Pop all three FIFOs together when all three are non-empty and the output register is free (!m_axis_tvalid || m_axis_tready).
- Vote on labels a (stream 1), b (stream 2), c (stream 3):
  - a==b or a==c → a.
  - Otherwise b==c → b.
  - Otherwise tie → label of input TIE_SEL.
- Decision word fields:
  - [15:0] winning label, zero-extended.
  - [16] unanimous (a==b==c).
  - [17] tie.
  - [18] last_mismatch: the three tlasts are not all equal.
  - [DATA_WIDTH-1:19] = 0.
- Output register is a single stage. m_axis_tdata, m_axis_tlast and m_axis_tvalid are all registered. The register holds its contents while m_axis_tvalid && !m_axis_tready.
- On a master handshake:
  - vote_count increments unless it is already 0xFFFF.
  - tie_count increments if bit 17 is set, unless it is already 0xFFFF.
- Reset (async assert, any cycle including mid-stream):
  - All FIFOs empty; in-flight data is discarded.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tkeep=0.
  - Both counters 0.
  - All s_axis_tready=0 while rst_n is low, 1 on the first cycle after deassertion.

## Timing
- Latency: a beat accepted in cycle N by the last of the three inputs produces m_axis_tvalid=1 in cycle N+2 (FIFO write at N, pop at N+1, output register at N+2).
- Throughput: with all inputs streaming and m_axis_tready held 1, one decision per cycle.
- Backpressure: with m_axis_tready low, pops stop. Each FIFO then accepts FIFO_DEPTH beats, after which its tready drops.
- Skew: one input may run up to FIFO_DEPTH samples ahead of the others. Its tready stalls and nothing is lost or reordered.
- AXI rules: m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid && !m_axis_tready. m_axis_tvalid never deasserts without a handshake.
- A push and a pop on the same non-full FIFO in one cycle both take effect; occupancy is unchanged.

## Test plan
- Majority: triples (a,b,c) = (3,3,5), (2,7,7), (4,9,4) → labels 3, 7, 4; bit16=0; bit17=0; vote_count ends at 3.
- Unanimous and tie, TIE_SEL=2: triples (6,6,6), (1,2,3) → first word 0x0001_0006; second word 0x0002_0003; tie_count=1.
- Skew and backpressure, FIFO_DEPTH=4, m_axis_tready=0:
  - Stream 1 sends 5 beats while streams 2 and 3 send none → s_axis_tready_1 low after 4 beats; no output.
  - Release the other streams and tready → 4 decisions in the original order, then the 5th beat is accepted.
- tlast: triple with tlast (1,1,1) → m_axis_tlast=1 and bit18=0. Triple with tlast (1,0,0) → m_axis_tlast=1 and bit18=1.
- Throughput and latency: 16 back-to-back aligned triples with m_axis_tready=1 → first m_axis_tvalid 2 cycles after the first accept, then 16 consecutive valid cycles.
- Reset mid-stream: assert rst_n low with 2 beats buffered and m_axis_tvalid=1.
  - Immediately: m_axis_tvalid=0, counters 0, all s_axis_tready=0.
  - After release, a new triple (5,5,1) yields label 5 with no stale output before it.
